status_led_ctrl: RTL and testbench

//  Parametrised successor to the single heartbeat-counter LED driver in our board tops.

---
 rtl/status_led_ctrl.sv | 99 +++++++++
 tb/tb_status_led_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/status_led_ctrl.sv
// Board-level status LED driver: lock-qualified reset hold-off, free-running heartbeat
// counter and NUM_LED independently moded LED channels.
module status_led_ctrl #(
  parameter int NUM_LED         = 4,
  parameter int CNT_WIDTH       = 32,
  parameter int HB_BIT          = 24,
  parameter int STRETCH_CYCLES  = 2500000,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   locked,
  output logic                   rst_out,
  input  logic [3*NUM_LED-1:0]   mode,
  input  logic [NUM_LED-1:0]     evt,
  output logic [NUM_LED-1:0]     led,
  output logic [CNT_WIDTH-1:0]   hb_count
);

  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);
  localparam logic [HW-1:0] HOLD_DONE    = HW'(RST_HOLD_CYCLES);

  typedef enum logic [2:0] {
    MODE_OFF       = 3'd0,
    MODE_ON        = 3'd1,
    MODE_HEARTBEAT = 3'd2,
    MODE_BLINK_SLO = 3'd3,
    MODE_BLINK_FST = 3'd4,
    MODE_STRETCH   = 3'd5,
    MODE_TOGGLE    = 3'd6,
    MODE_RSVD      = 3'd7
  } led_mode_t;

  logic [HW-1:0]      hold_cnt;
  logic [SW-1:0]      stretch [NUM_LED];
  logic [NUM_LED-1:0] toggle;
  logic [NUM_LED-1:0] led_next;

  // A lock drop restarts the whole hold-off and the heartbeat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      rst_out  <= 1'b1;
      hb_count <= '0;
    end else if (!locked) begin
      hold_cnt <= '0;
      rst_out  <= 1'b1;
      hb_count <= '0;
    end else begin
      if (hold_cnt != HOLD_DONE)
        hold_cnt <= hold_cnt + HW'(1);
      rst_out  <= (hold_cnt != HOLD_DONE);
      hb_count <= hb_count + CNT_WIDTH'(1);
    end
  end

  // Channel state ignores mode so switching modes never loses an event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LED; i++)
        stretch[i] <= '0;
      toggle <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        if (evt[i])
          stretch[i] <= STRETCH_LOAD;
        else if (stretch[i] != '0)
          stretch[i] <= stretch[i] - SW'(1);
      end
      toggle <= toggle ^ evt;
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      case (led_mode_t'(mode[3*i +: 3]))
        MODE_OFF:       led_next[i] = 1'b0;
        MODE_ON:        led_next[i] = 1'b1;
        MODE_HEARTBEAT: led_next[i] = hb_count[HB_BIT+i];
        MODE_BLINK_SLO: led_next[i] = hb_count[HB_BIT+NUM_LED-1];
        MODE_BLINK_FST: led_next[i] = hb_count[HB_BIT];
        MODE_STRETCH:   led_next[i] = (stretch[i] != '0);
        MODE_TOGGLE:    led_next[i] = toggle[i];
        default:        led_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      led <= '0;
    else
      led <= led_next;
  end

endmodule

// File: tb/tb_status_led_ctrl.sv
// Directed bench for status_led_ctrl: stimulus pushes expected outputs into a scoreboard
// queue, a negedge monitor pops and compares them.
module tb_status_led_ctrl;

  localparam logic [11:0] M_HB  = 12'h492;  // all heartbeat
  localparam logic [11:0] M_BL  = 12'h01C;  // ch0 fast, ch1 slow
  localparam logic [11:0] M_ST  = 12'h005;  // ch0 stretch
  localparam logic [11:0] M_TG  = 12'h030;  // ch1 toggle
  localparam logic [11:0] M_RS  = 12'hFFF;  // all reserved
  localparam logic [11:0] M_MID = 12'h035;  // ch1 toggle, ch0 stretch

  typedef struct packed {
    logic [15:0] id;
    logic        chk_rst;
    logic        rst;
    logic [3:0]  led_mask;
    logic [3:0]  led;
    logic        chk_hb;
    logic [7:0]  hb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        locked = 1'b0;
  logic        rst_out;
  logic [11:0] mode = '0;
  logic [3:0]  evt = '0;
  logic [3:0]  led;
  logic [7:0]  hb_count;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step_id = 0;

  bit          st_ev  [17] = '{1,0,0,0,0,0,0, 1,0,0,0,1,0,0,0,0,0};
  bit          st_led [17] = '{0,1,1,1,1,0,0, 0,1,1,1,1,1,1,1,1,0};
  logic [11:0] tg_md  [15] = '{M_TG, M_TG, M_TG, M_TG, M_TG, M_TG, 12'h000, 12'h000, M_TG,
                               M_TG, M_TG, M_TG, M_RS, 12'h000, M_ST};
  logic [3:0]  tg_ev  [15] = '{4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,
                               4'h2, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0};
  logic [3:0]  tg_led [15] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2,
                               4'h2, 4'h0, 4'h2, 4'h0, 4'h0, 4'h1};

  status_led_ctrl #(
    .NUM_LED(4), .CNT_WIDTH(8), .HB_BIT(2), .STRETCH_CYCLES(4), .RST_HOLD_CYCLES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .locked(locked), .rst_out(rst_out),
    .mode(mode), .evt(evt), .led(led), .hb_count(hb_count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic lk, input logic [11:0] md, input logic [3:0] ev,
                      input logic cr, input logic r, input logic [3:0] lm, input logic [3:0] l,
                      input logic ch, input logic [7:0] h);
    exp_t e;
    reset_n = rn; locked = lk; mode = md; evt = ev;
    @(posedge clk);
    e.id = 16'(step_id); e.chk_rst = cr; e.rst = r; e.led_mask = lm; e.led = l;
    e.chk_hb = ch; e.hb = h;
    sb.push_back(e);
    step_id++;
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_rst) begin
          checks++;
          if (rst_out !== e.rst) begin
            failures++;
            $display("FAIL rst_out step%0d got=%b exp=%b", e.id, rst_out, e.rst);
          end
        end
        if (e.led_mask != 4'h0) begin
          checks++;
          if ((led & e.led_mask) !== (e.led & e.led_mask)) begin
            failures++;
            $display("FAIL led step%0d got=%b exp=%b mask=%b", e.id, led, e.led, e.led_mask);
          end
        end
        if (e.chk_hb) begin
          checks++;
          if (hb_count !== e.hb) begin
            failures++;
            $display("FAIL hb_count step%0d got=%0d exp=%0d", e.id, hb_count, e.hb);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] hbv;
    logic [7:0] prev;

    // reset then lock: hold-off of 3 cycles
    step(0, 1, 12'h0, 4'h0, 1, 1, 4'hF, 4'h0, 1, 8'd0);
    step(0, 1, 12'h0, 4'h0, 1, 1, 4'hF, 4'h0, 1, 8'd0);
    for (int k = 1; k <= 6; k++)
      step(1, 1, 12'h0, 4'h0, 1, (k < 4), 4'hF, 4'h0, 1, 8'(k));

    // single-cycle lock glitch
    step(1, 0, 12'h0, 4'h0, 1, 1, 4'hF, 4'h0, 1, 8'd0);
    for (int k = 1; k <= 4; k++)
      step(1, 1, 12'h0, 4'h0, 1, (k < 4), 4'hF, 4'h0, 1, 8'(k));

    // heartbeat taps, counter wrap, then fast vs slow blink
    hbv = 8'd4;
    for (int n = 0; n < 300; n++) begin
      prev = hbv;
      hbv  = prev + 8'd1;
      step(1, 1, M_HB, 4'h0, 1, 0, 4'hF, prev[5:2], 1, hbv);
    end
    for (int n = 0; n < 70; n++) begin
      prev = hbv;
      hbv  = prev + 8'd1;
      step(1, 1, M_BL, 4'h0, 1, 0, 4'hF, {2'b00, prev[5], prev[2]}, 1, hbv);
    end

    // event stretch and retrigger on the last lit cycle
    step(1, 1, M_ST, 4'h0, 0, 0, 4'hF, 4'h0, 0, 8'd0);
    for (int n = 0; n < 17; n++)
      step(1, 1, M_ST, {3'b000, st_ev[n]}, 0, 0, 4'hF, {3'b000, st_led[n]}, 0, 8'd0);

    // toggle, mode swap retention, double pulse, reserved mode, stretch independent of mode
    for (int n = 0; n < 15; n++)
      step(1, 1, tg_md[n], tg_ev[n], 0, 0, 4'hF, tg_led[n], 0, 8'd0);
    for (int n = 0; n < 6; n++)
      step(1, 1, 12'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 8'd0);

    // event during rst_out, then reset mid-stretch and mid-hold-off
    step(1, 0, M_MID, 4'h1, 1, 1, 4'h0, 4'h0, 1, 8'd0);
    step(1, 1, M_MID, 4'h0, 1, 1, 4'hF, 4'h3, 1, 8'd1);
    step(0, 1, M_MID, 4'h0, 1, 1, 4'hF, 4'h0, 1, 8'd0);
    for (int k = 1; k <= 4; k++)
      step(1, 1, M_MID, 4'h0, 1, (k < 4), 4'hF, 4'h0, 1, 8'(k));

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
